// File: rtl/id_ex_pipe_reg.sv
// Decode->Execute pipeline register with stall (hold), flush (bubble insert) and a
// saturating count of inserted bubbles. All outputs are registered.
module id_ex_pipe_reg #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int ALU_CTRL_WIDTH = 3,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      StallE,
    input  logic                      FlushE,
    input  logic                      ValidD,
    input  logic [DATA_WIDTH-1:0]     RD1D,
    input  logic [DATA_WIDTH-1:0]     RD2D,
    input  logic [DATA_WIDTH-1:0]     PCD,
    input  logic [DATA_WIDTH-1:0]     PCPlus4D,
    input  logic [DATA_WIDTH-1:0]     ExtImmD,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
    input  logic [REG_ADDR_WIDTH-1:0] RdD,
    input  logic                      RegWriteD,
    input  logic [1:0]                ResultSrcD,
    input  logic                      MemWriteD,
    input  logic                      JumpD,
    input  logic                      BranchD,
    input  logic [ALU_CTRL_WIDTH-1:0] ALUControlD,
    input  logic                      ALUSrcD,
    output logic                      ValidE,
    output logic [DATA_WIDTH-1:0]     RD1E,
    output logic [DATA_WIDTH-1:0]     RD2E,
    output logic [DATA_WIDTH-1:0]     PCE,
    output logic [DATA_WIDTH-1:0]     PCPlus4E,
    output logic [DATA_WIDTH-1:0]     ExtImmE,
    output logic [REG_ADDR_WIDTH-1:0] Rs1E,
    output logic [REG_ADDR_WIDTH-1:0] Rs2E,
    output logic [REG_ADDR_WIDTH-1:0] RdE,
    output logic                      RegWriteE,
    output logic [1:0]                ResultSrcE,
    output logic                      MemWriteE,
    output logic                      JumpE,
    output logic                      BranchE,
    output logic [ALU_CTRL_WIDTH-1:0] ALUControlE,
    output logic                      ALUSrcE,
    output logic [CNT_WIDTH-1:0]      BubbleCount
);

    typedef struct packed {
        logic                      valid;
        logic [DATA_WIDTH-1:0]     rd1;
        logic [DATA_WIDTH-1:0]     rd2;
        logic [DATA_WIDTH-1:0]     pc;
        logic [DATA_WIDTH-1:0]     pcplus4;
        logic [DATA_WIDTH-1:0]     extimm;
        logic [REG_ADDR_WIDTH-1:0] rs1;
        logic [REG_ADDR_WIDTH-1:0] rs2;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      regwrite;
        logic [1:0]                resultsrc;
        logic                      memwrite;
        logic                      jump;
        logic                      branch;
        logic [ALU_CTRL_WIDTH-1:0] aluctrl;
        logic                      alusrc;
    } slot_t;

    slot_t                slot_in;
    slot_t                slot_d, slot_q;
    logic [CNT_WIDTH-1:0] cnt_d, cnt_q;

    assign slot_in = '{
        valid:     ValidD,
        rd1:       RD1D,
        rd2:       RD2D,
        pc:        PCD,
        pcplus4:   PCPlus4D,
        extimm:    ExtImmD,
        rs1:       Rs1D,
        rs2:       Rs2D,
        rd:        RdD,
        regwrite:  RegWriteD,
        resultsrc: ResultSrcD,
        memwrite:  MemWriteD,
        jump:      JumpD,
        branch:    BranchD,
        aluctrl:   ALUControlD,
        alusrc:    ALUSrcD
    };

    // Bubble is the all-zero slot, identical to the reset state, so Execute
    // never has to distinguish a flushed slot from a post-reset one.
    always_comb begin
        slot_d = slot_q;
        cnt_d  = cnt_q;
        if (FlushE) begin
            slot_d = '0;
            if (cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1);
        end else if (!StallE) begin
            slot_d = slot_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_q <= '0;
            cnt_q  <= '0;
        end else begin
            slot_q <= slot_d;
            cnt_q  <= cnt_d;
        end
    end

    assign ValidE      = slot_q.valid;
    assign RD1E        = slot_q.rd1;
    assign RD2E        = slot_q.rd2;
    assign PCE         = slot_q.pc;
    assign PCPlus4E    = slot_q.pcplus4;
    assign ExtImmE     = slot_q.extimm;
    assign Rs1E        = slot_q.rs1;
    assign Rs2E        = slot_q.rs2;
    assign RdE         = slot_q.rd;
    assign RegWriteE   = slot_q.regwrite;
    assign ResultSrcE  = slot_q.resultsrc;
    assign MemWriteE   = slot_q.memwrite;
    assign JumpE       = slot_q.jump;
    assign BranchE     = slot_q.branch;
    assign ALUControlE = slot_q.aluctrl;
    assign ALUSrcE     = slot_q.alusrc;
    assign BubbleCount = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: directed vector table, randomized run against a
// reference model, and a saturation sequence on a narrow-counter instance.
module tb_id_ex_pipe_reg;

    typedef struct packed {
        logic        valid;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] pc;
        logic [31:0] pcplus4;
        logic [31:0] extimm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        regwrite;
        logic [1:0]  resultsrc;
        logic        memwrite;
        logic        jump;
        logic        branch;
        logic [2:0]  aluctrl;
        logic        alusrc;
    } slot_t;

    typedef struct {
        logic        rst_n, stall, flush, v;
        logic [31:0] pc, imm;
        logic [4:0]  rd;
        logic        rw, mw;
        logic        ev;
        logic [31:0] epc, eimm;
        logic [4:0]  erd;
        logic        erw, emw;
        int          ebc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n, StallE, FlushE;
    slot_t       d, e, e4, mdl;
    logic [15:0] bc;
    logic [3:0]  bc4;
    int          errors = 0;
    int          checks = 0;
    int          flushes = 0;
    vec_t        tbl[15];

    always #5 clk = ~clk;

    id_ex_pipe_reg u_dut (
        .clk(clk), .rst_n(rst_n), .StallE(StallE), .FlushE(FlushE),
        .ValidD(d.valid), .RD1D(d.rd1), .RD2D(d.rd2), .PCD(d.pc), .PCPlus4D(d.pcplus4),
        .ExtImmD(d.extimm), .Rs1D(d.rs1), .Rs2D(d.rs2), .RdD(d.rd), .RegWriteD(d.regwrite),
        .ResultSrcD(d.resultsrc), .MemWriteD(d.memwrite), .JumpD(d.jump), .BranchD(d.branch),
        .ALUControlD(d.aluctrl), .ALUSrcD(d.alusrc),
        .ValidE(e.valid), .RD1E(e.rd1), .RD2E(e.rd2), .PCE(e.pc), .PCPlus4E(e.pcplus4),
        .ExtImmE(e.extimm), .Rs1E(e.rs1), .Rs2E(e.rs2), .RdE(e.rd), .RegWriteE(e.regwrite),
        .ResultSrcE(e.resultsrc), .MemWriteE(e.memwrite), .JumpE(e.jump), .BranchE(e.branch),
        .ALUControlE(e.aluctrl), .ALUSrcE(e.alusrc), .BubbleCount(bc)
    );

    id_ex_pipe_reg #(.CNT_WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .StallE(StallE), .FlushE(FlushE),
        .ValidD(d.valid), .RD1D(d.rd1), .RD2D(d.rd2), .PCD(d.pc), .PCPlus4D(d.pcplus4),
        .ExtImmD(d.extimm), .Rs1D(d.rs1), .Rs2D(d.rs2), .RdD(d.rd), .RegWriteD(d.regwrite),
        .ResultSrcD(d.resultsrc), .MemWriteD(d.memwrite), .JumpD(d.jump), .BranchD(d.branch),
        .ALUControlD(d.aluctrl), .ALUSrcD(d.alusrc),
        .ValidE(e4.valid), .RD1E(e4.rd1), .RD2E(e4.rd2), .PCE(e4.pc), .PCPlus4E(e4.pcplus4),
        .ExtImmE(e4.extimm), .Rs1E(e4.rs1), .Rs2E(e4.rs2), .RdE(e4.rd), .RegWriteE(e4.regwrite),
        .ResultSrcE(e4.resultsrc), .MemWriteE(e4.memwrite), .JumpE(e4.jump), .BranchE(e4.branch),
        .ALUControlE(e4.aluctrl), .ALUSrcE(e4.alusrc), .BubbleCount(bc4)
    );

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int sat(input int n, input int mx);
        return (n > mx) ? mx : n;
    endfunction

    task automatic randomize_d();
        logic [191:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        d = r[$bits(slot_t)-1:0];
    endtask

    // Model: the E slot is the last instruction accepted; reset/flush empty it.
    task automatic step();
        if (!rst_n) begin
            mdl = '0;
            flushes = 0;
        end else if (FlushE) begin
            mdl = '0;
            flushes++;
        end else if (!StallE) begin
            mdl = d;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{0,0,0,1,32'hFFFF_FFFF,32'hFFFF_FFFF,31,1,1, 0,32'h0,32'h0,0,0,0, 0};
        tbl[1]  = '{0,1,1,1,32'hFFFF_FFFF,32'hFFFF_FFFF,31,1,1, 0,32'h0,32'h0,0,0,0, 0};
        tbl[2]  = '{1,0,0,1,32'h0,32'hFFFF_F800,7,1,0, 1,32'h0,32'hFFFF_F800,7,1,0, 0};
        tbl[3]  = '{1,0,0,1,32'h100,32'h0,1,0,0, 1,32'h100,32'h0,1,0,0, 0};
        tbl[4]  = '{1,1,0,1,32'h104,32'h123,2,1,1, 1,32'h100,32'h0,1,0,0, 0};
        tbl[5]  = '{1,1,0,1,32'h104,32'h123,2,1,1, 1,32'h100,32'h0,1,0,0, 0};
        tbl[6]  = '{1,1,0,1,32'h104,32'h123,2,1,1, 1,32'h100,32'h0,1,0,0, 0};
        tbl[7]  = '{1,0,0,1,32'h104,32'h0,2,0,0, 1,32'h104,32'h0,2,0,0, 0};
        tbl[8]  = '{1,1,1,1,32'h108,32'h55,4,1,1, 0,32'h0,32'h0,0,0,0, 1};
        tbl[9]  = '{1,0,0,1,32'h200,32'h8,9,1,0, 1,32'h200,32'h8,9,1,0, 1};
        tbl[10] = '{1,1,0,1,32'h204,32'h9,5,0,1, 1,32'h200,32'h8,9,1,0, 1};
        tbl[11] = '{0,1,0,1,32'h204,32'h9,5,0,1, 0,32'h0,32'h0,0,0,0, 0};
        tbl[12] = '{1,0,0,1,32'h300,32'h7FF,3,1,0, 1,32'h300,32'h7FF,3,1,0, 0};
        tbl[13] = '{1,0,1,1,32'h304,32'h1,4,1,1, 0,32'h0,32'h0,0,0,0, 1};
        tbl[14] = '{1,0,1,0,32'h308,32'h2,6,1,1, 0,32'h0,32'h0,0,0,0, 2};

        rst_n = 1'b0; StallE = 1'b0; FlushE = 1'b0; d = '0; mdl = '0;

        foreach (tbl[i]) begin
            randomize_d();
            if (!tbl[i].rst_n) d = '1;
            rst_n      = tbl[i].rst_n;
            StallE     = tbl[i].stall;
            FlushE     = tbl[i].flush;
            d.valid    = tbl[i].v;
            d.pc       = tbl[i].pc;
            d.extimm   = tbl[i].imm;
            d.rd       = tbl[i].rd;
            d.regwrite = tbl[i].rw;
            d.memwrite = tbl[i].mw;
            step();
            chk($sformatf("vec%0d_valid", i), e.valid, tbl[i].ev);
            chk($sformatf("vec%0d_pc", i), e.pc, tbl[i].epc);
            chk($sformatf("vec%0d_imm", i), e.extimm, tbl[i].eimm);
            chk($sformatf("vec%0d_rd", i), e.rd, tbl[i].erd);
            chk($sformatf("vec%0d_regwrite", i), e.regwrite, tbl[i].erw);
            chk($sformatf("vec%0d_memwrite", i), e.memwrite, tbl[i].emw);
            chk($sformatf("vec%0d_bc", i), bc, 256'(tbl[i].ebc));
            chk($sformatf("vec%0d_bc4", i), bc4, 256'(tbl[i].ebc));
            if (!tbl[i].rst_n || tbl[i].flush)
                chk($sformatf("vec%0d_all_zero", i), e, 256'(0));
        end

        // Randomized run against the model
        for (int n = 0; n < 400; n++) begin
            randomize_d();
            rst_n  = ($urandom_range(0, 24) != 0);
            StallE = ($urandom_range(0, 3) == 0);
            FlushE = ($urandom_range(0, 5) == 0);
            step();
            chk("rand_e", e, mdl);
            chk("rand_e4", e4, mdl);
            chk("rand_bc", bc, 256'(sat(flushes, 65535)));
            chk("rand_bc4", bc4, 256'(sat(flushes, 15)));
        end

        // Saturation on the 4-bit counter; D fields high with ValidD low
        rst_n = 1'b0; StallE = 1'b0; FlushE = 1'b0;
        step();
        chk("sat_reset_bc4", bc4, 256'(0));
        rst_n = 1'b1; FlushE = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            d = '1;
            d.valid = 1'b0;
            StallE = n[0];
            step();
            chk($sformatf("sat_bc4_%0d", n), bc4, 256'(sat(n, 15)));
            chk($sformatf("sat_wr_%0d", n), {e4.regwrite, e4.memwrite, e.regwrite, e.memwrite}, 256'(0));
        end
        chk("sat_bc_wide", bc, 256'(20));
        FlushE = 1'b0; StallE = 1'b1;
        step();
        chk("sat_hold_stall", bc4, 256'(15));
        StallE = 1'b0;
        randomize_d();
        step();
        chk("sat_hold_load", bc4, 256'(15));
        chk("sat_load_e", e, mdl);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
